// File: rtl/fw_fifo_pkg.sv
// fw_fifo_pkg: default constants and parameter legality check for fw_sync_fifo
// Contents:
//   FIFO_WIDTH_DEF, FIFO_DEPTH_DEF - default WIDTH / DEPTH
//   fifo_params_ok(width, depth, thresh) - legality of a parameter set
package fw_fifo_pkg;
    import primitives_pkg::*;

    localparam int FIFO_WIDTH_DEF = 8;
    localparam int FIFO_DEPTH_DEF = 16;

    function automatic bit fifo_params_ok(int width, int depth, int thresh);
        return (width >= 1) && (width <= 64) && (depth >= 2) && is_pow2(depth) &&
               (thresh >= 1) && (thresh <= depth);
    endfunction
endpackage

// File: rtl/primitives_pkg.sv
// primitives_pkg: small generic helpers shared across blocks
// Contents:
//   is_pow2(v) - true when v is a positive power of two
package primitives_pkg;
    function automatic bit is_pow2(int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction
endpackage

// File: rtl/fw_fifo_mem.sv
// fw_fifo_mem: DEPTH x WIDTH storage, one synchronous write port, one asynchronous read port
// Ports:
//   i_clk   - write clock
//   i_we    - write enable
//   i_waddr - write index
//   i_wdata - write word
//   i_raddr - read index
//   o_rdata - word at i_raddr (combinational)
// The array is intentionally not reset.
module fw_fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [WIDTH-1:0]         o_rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge i_clk)
        if (i_we) mem[i_waddr] <= i_wdata;

    assign o_rdata = mem[i_raddr];
endmodule

// File: rtl/fw_sync_fifo.sv
// fw_sync_fifo: single-clock first-word fall-through FIFO with almost-full flag
// Ports:
//   i_clk, i_rst  - clock, asynchronous active-high reset
//   i_wr_valid, o_wr_ready, i_wr_data - write handshake
//   o_rd_valid, i_rd_ready, o_rd_data - read handshake (head word, zero when empty)
//   o_almost_full - level >= AFULL_THRESH
//   o_level       - occupancy 0..DEPTH, present only with FW_SYNC_FIFO_LEVEL_EN defined
module fw_sync_fifo
    import fw_fifo_pkg::*;
#(
    parameter int WIDTH        = FIFO_WIDTH_DEF,
    parameter int DEPTH        = FIFO_DEPTH_DEF,
    parameter int AFULL_THRESH = DEPTH - 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wr_valid,
    output logic             o_wr_ready,
    input  logic [WIDTH-1:0] i_wr_data,
    output logic             o_rd_valid,
    input  logic             i_rd_ready,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_almost_full
`ifdef FW_SYNC_FIFO_LEVEL_EN
    ,
    output logic [$clog2(DEPTH):0] o_level
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE    = (AW + 1)'(1);
    localparam logic [AW:0] THRESH = (AW + 1)'(AFULL_THRESH);

    if (!fifo_params_ok(WIDTH, DEPTH, AFULL_THRESH)) begin : g_bad_params
        $fatal(1, "fw_sync_fifo: illegal WIDTH/DEPTH/AFULL_THRESH");
    end

    logic [AW:0]      wr_ptr, rd_ptr, level;
    logic [WIDTH-1:0] mem_q;
    logic             full, empty, push, pop;

    // Equal indices mean empty when the wrap bits agree and full when they differ.
    assign empty = wr_ptr == rd_ptr;
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign push  = i_wr_valid && !full;
    assign pop   = i_rd_ready && !empty;

    assign o_wr_ready    = !full;
    assign o_rd_valid    = !empty;
    assign o_rd_data     = empty ? '0 : mem_q;
    assign o_almost_full = level >= THRESH;

    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + ONE;
            if (pop) rd_ptr <= rd_ptr + ONE;
            if (push != pop) level <= push ? level + ONE : level - ONE;
        end

`ifdef FW_SYNC_FIFO_LEVEL_EN
    assign o_level = level;
`endif

    fw_fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
        .i_clk  (i_clk),
        .i_we   (push),
        .i_waddr(wr_ptr[AW-1:0]),
        .i_wdata(i_wr_data),
        .i_raddr(rd_ptr[AW-1:0]),
        .o_rdata(mem_q)
    );
endmodule

// File: tb/tb_fw_sync_fifo.sv
// tb_fw_sync_fifo: self-checking bench for fw_sync_fifo (WIDTH=8, DEPTH=4, AFULL_THRESH=3)
module tb_fw_sync_fifo;
    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_wr_valid = 1'b0;
    logic       o_wr_ready;
    logic [7:0] i_wr_data = 8'h00;
    logic       o_rd_valid;
    logic       i_rd_ready = 1'b0;
    logic [7:0] o_rd_data;
    logic       o_almost_full;
`ifdef FW_SYNC_FIFO_LEVEL_EN
    logic [2:0] o_level;
`endif

    fw_sync_fifo #(.WIDTH(8), .DEPTH(4), .AFULL_THRESH(3)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_wr_valid   (i_wr_valid),
        .o_wr_ready   (o_wr_ready),
        .i_wr_data    (i_wr_data),
        .o_rd_valid   (o_rd_valid),
        .i_rd_ready   (i_rd_ready),
        .o_rd_data    (o_rd_data),
        .o_almost_full(o_almost_full)
`ifdef FW_SYNC_FIFO_LEVEL_EN
        ,
        .o_level      (o_level)
`endif
    );

    always #5 i_clk = ~i_clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic       wv;
        logic [7:0] wd;
        logic       rr;
        logic       ready;
        logic       valid;
        logic [7:0] data;
        logic       af;
        logic [2:0] lvl;
    } vec_t;

    vec_t vecs[19];
    logic [7:0] q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic ready, input logic valid,
                             input logic [7:0] data, input logic af, input logic [2:0] lvl);
        chk({tag, ".wr_ready"}, 32'(o_wr_ready), 32'(ready));
        chk({tag, ".rd_valid"}, 32'(o_rd_valid), 32'(valid));
        chk({tag, ".rd_data"}, 32'(o_rd_data), 32'(data));
        chk({tag, ".almost_full"}, 32'(o_almost_full), 32'(af));
`ifdef FW_SYNC_FIFO_LEVEL_EN
        chk({tag, ".level"}, 32'(o_level), 32'(lvl));
`else
        if (lvl > 3'd4) $display("FAIL %s.level_model: got %0d expected <=4", tag, lvl);
`endif
    endtask

    task automatic step(input logic wv, input logic [7:0] wd, input logic rr);
        i_wr_valid = wv;
        i_wr_data  = wd;
        i_rd_ready = rr;
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 8'hA1, 1'b0, 1'b1, 1'b1, 8'hA1, 1'b0, 3'd1};
        vecs[1]  = '{1'b1, 8'hA2, 1'b0, 1'b1, 1'b1, 8'hA1, 1'b0, 3'd2};
        vecs[2]  = '{1'b1, 8'hA3, 1'b0, 1'b1, 1'b1, 8'hA1, 1'b1, 3'd3};
        vecs[3]  = '{1'b1, 8'hA4, 1'b0, 1'b0, 1'b1, 8'hA1, 1'b1, 3'd4};
        vecs[4]  = '{1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 8'hA1, 1'b1, 3'd4};
        vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA2, 1'b1, 3'd3};
        vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA3, 1'b0, 3'd2};
        vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA4, 1'b0, 3'd1};
        vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0};
        vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0};
        vecs[10] = '{1'b1, 8'hC1, 1'b0, 1'b1, 1'b1, 8'hC1, 1'b0, 3'd1};
        vecs[11] = '{1'b1, 8'hC2, 1'b0, 1'b1, 1'b1, 8'hC1, 1'b0, 3'd2};
        vecs[12] = '{1'b1, 8'hC3, 1'b0, 1'b1, 1'b1, 8'hC1, 1'b1, 3'd3};
        vecs[13] = '{1'b1, 8'hC4, 1'b0, 1'b0, 1'b1, 8'hC1, 1'b1, 3'd4};
        vecs[14] = '{1'b1, 8'hB0, 1'b1, 1'b1, 1'b1, 8'hC2, 1'b1, 3'd3};
        vecs[15] = '{1'b1, 8'hD0, 1'b1, 1'b1, 1'b1, 8'hC3, 1'b1, 3'd3};
        vecs[16] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hC4, 1'b0, 3'd2};
        vecs[17] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hD0, 1'b0, 3'd1};
        vecs[18] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0};

        repeat (3) @(posedge i_clk);
        #1 i_rst = 1'b0;
        step(1'b0, 8'h00, 1'b0);
        check_all("reset_idle", 1'b1, 1'b0, 8'h00, 1'b0, 3'd0);

        for (int i = 0; i < 19; i++) begin
            step(vecs[i].wv, vecs[i].wd, vecs[i].rr);
            check_all($sformatf("vec%0d", i), vecs[i].ready, vecs[i].valid,
                      vecs[i].data, vecs[i].af, vecs[i].lvl);
        end

        for (int i = 0; i < 10; i++) begin
            step(1'b1, 8'(i), 1'b1);
            check_all($sformatf("stream%0d", i), 1'b1, 1'b1, 8'(i), 1'b0, 3'd1);
        end
        step(1'b0, 8'h00, 1'b1);
        check_all("stream_drain", 1'b1, 1'b0, 8'h00, 1'b0, 3'd0);

        step(1'b1, 8'h11, 1'b0);
        step(1'b1, 8'h22, 1'b0);
        check_all("pre_async_rst", 1'b1, 1'b1, 8'h11, 1'b0, 3'd2);
        i_wr_valid = 1'b0;
        @(negedge i_clk);
        i_rst = 1'b1;
        #1;
        check_all("async_rst", 1'b1, 1'b0, 8'h00, 1'b0, 3'd0);
        @(posedge i_clk);
        #1 i_rst = 1'b0;
        step(1'b1, 8'h55, 1'b0);
        check_all("post_rst_push", 1'b1, 1'b1, 8'h55, 1'b0, 3'd1);
        step(1'b0, 8'h00, 1'b1);
        check_all("post_rst_pop", 1'b1, 1'b0, 8'h00, 1'b0, 3'd0);

        q = {};
        for (int i = 0; i < 400; i++) begin
            logic       wv, rr, do_push, do_pop;
            logic [7:0] wd;
            wv = 1'($urandom_range(0, 1));
            rr = 1'($urandom_range(0, 1));
            wd = 8'($urandom);
            do_push = wv && (q.size() != 4);
            do_pop  = rr && (q.size() != 0);
            step(wv, wd, rr);
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(wd);
            check_all($sformatf("rand%0d", i), q.size() != 4, q.size() != 0,
                      q.size() != 0 ? q[0] : 8'h00, q.size() >= 3, 3'(q.size()));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
